cv32e40p_ft_supervisor: RTL and testbench

- Central collector and controller at the far end of the fault-tolerance status interface exported by every TMR-wrapped block (is_broken_o, err_detected_o, err_corrected_o in; set_broken_i out).
- Counts detected, corrected and uncorrected errors and tracks per-replica breakage.
- Runs a health FSM (NOMINAL/DEGRADED/FAILED), raises an interrupt, and exposes a small register port for software to read status and force replicas broken.
- Sits beside the core, wired to N_BLOCKS FT wrappers.

---
 rtl/cv32e40p_ft_supervisor.sv | 138 +++++++++++++
 tb/tb_cv32e40p_ft_supervisor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ft_supervisor.sv
// Fault-tolerance supervisor: counts TMR error events, tracks replica breakage, runs a health FSM,
// raises a level IRQ and serves a small 1-cycle-latency register port (no backpressure).
module cv32e40p_ft_supervisor #(
  parameter int N_BLOCKS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*N_BLOCKS-1:0] is_broken_i,
  input  logic [N_BLOCKS-1:0]   err_detected_i,
  input  logic [N_BLOCKS-1:0]   err_corrected_i,
  output logic [3*N_BLOCKS-1:0] set_broken_o,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [2:0]            reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_valid_o,
  output logic                  irq_o,
  output logic [1:0]            health_o
);

  localparam int NB3 = 3 * N_BLOCKS;
  localparam logic [32:0] CNT_MAX = (33'd1 << CNT_W) - 33'd1;

  typedef enum logic [1:0] {
    NOMINAL  = 2'd0,
    DEGRADED = 2'd1,
    FAILED   = 2'd2
  } health_t;

  health_t              state_q, state_d;
  logic [CNT_W-1:0]     det_cnt, cor_cnt, unc_cnt;
  logic [NB3-1:0]       force_q;
  logic [1:0]           irq_en_q;
  logic [N_BLOCKS-1:0]  unc, det_cor;
  logic                 any_broken, multi_broken, fail_cond, clr;
  logic [31:0]          rdata_d;
  logic                 unused_wdata;

  function automatic logic [5:0] popcnt(input logic [N_BLOCKS-1:0] v);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < N_BLOCKS; i++) p = p + 6'(v[i]);
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [5:0] p);
    logic [32:0] s;
    s = 33'(c) + 33'(p);
    if (s > CNT_MAX) return CNT_MAX[CNT_W-1:0];
    return s[CNT_W-1:0];
  endfunction

  assign unc          = err_detected_i & ~err_corrected_i;
  assign det_cor      = err_detected_i & err_corrected_i;
  assign any_broken   = |is_broken_i;
  assign clr          = reg_req_i & reg_we_i & (reg_addr_i == 3'd0) & reg_wdata_i[0];
  assign unused_wdata = ^reg_wdata_i;

  // A block is lost once two of its three replicas are broken (majority gone).
  always_comb begin
    multi_broken = 1'b0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      multi_broken = multi_broken |
        (is_broken_i[3*k] & is_broken_i[3*k+1]) |
        (is_broken_i[3*k] & is_broken_i[3*k+2]) |
        (is_broken_i[3*k+1] & is_broken_i[3*k+2]);
    end
  end

  assign fail_cond = (|unc) | multi_broken;

  // Failure beats a simultaneous clear so a persisting fault cannot be cleared away.
  always_comb begin
    state_d = state_q;
    if (fail_cond) begin
      state_d = FAILED;
    end else if (clr) begin
      state_d = any_broken ? DEGRADED : NOMINAL;
    end else begin
      case (state_q)
        NOMINAL: if (any_broken || (cor_cnt != '0)) state_d = DEGRADED;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!reg_we_i) begin
      case (reg_addr_i)
        3'd0:    rdata_d = {29'd0, any_broken, state_q};
        3'd1:    rdata_d = 32'(det_cnt);
        3'd2:    rdata_d = 32'(cor_cnt);
        3'd3:    rdata_d = 32'(unc_cnt);
        3'd4:    rdata_d = 32'(is_broken_i);
        3'd5:    rdata_d = 32'(force_q);
        3'd6:    rdata_d = {30'd0, irq_en_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NOMINAL;
      det_cnt     <= '0;
      cor_cnt     <= '0;
      unc_cnt     <= '0;
      force_q     <= '0;
      irq_en_q    <= '0;
      irq_o       <= 1'b0;
      reg_valid_o <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        det_cnt <= '0;
        cor_cnt <= '0;
        unc_cnt <= '0;
      end else begin
        det_cnt <= sat_add(det_cnt, popcnt(err_detected_i));
        cor_cnt <= sat_add(cor_cnt, popcnt(det_cor));
        unc_cnt <= sat_add(unc_cnt, popcnt(unc));
      end
      if (reg_req_i && reg_we_i && (reg_addr_i == 3'd5)) force_q  <= reg_wdata_i[NB3-1:0];
      if (reg_req_i && reg_we_i && (reg_addr_i == 3'd6)) irq_en_q <= reg_wdata_i[1:0];
      irq_o       <= (irq_en_q[0] & (state_q == DEGRADED)) | (irq_en_q[1] & (state_q == FAILED));
      reg_valid_o <= reg_req_i;
      reg_rdata_o <= reg_req_i ? rdata_d : 32'd0;
    end
  end

  assign set_broken_o = force_q;
  assign health_o     = state_q;

endmodule

// File: tb/tb_cv32e40p_ft_supervisor.sv
// Directed bench for cv32e40p_ft_supervisor; a second instance with CNT_W=4 covers saturation.
module tb_cv32e40p_ft_supervisor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] is_broken = '0;
  logic [3:0]  det = '0, cor = '0;
  logic [11:0] set_broken;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        valid, irq;
  logic [1:0]  health;

  logic [3:0]  det_s = '0, cor_s = '0;
  logic [11:0] set_broken_s;
  logic        req_s = 1'b0;
  logic [2:0]  addr_s = '0;
  logic [31:0] rdata_s;
  logic        valid_s, irq_s;
  logic [1:0]  health_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cv32e40p_ft_supervisor #(.N_BLOCKS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .is_broken_i(is_broken), .err_detected_i(det),
    .err_corrected_i(cor), .set_broken_o(set_broken), .reg_req_i(req), .reg_we_i(we),
    .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_rdata_o(rdata), .reg_valid_o(valid),
    .irq_o(irq), .health_o(health)
  );

  cv32e40p_ft_supervisor #(.N_BLOCKS(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .is_broken_i(12'h000), .err_detected_i(det_s),
    .err_corrected_i(cor_s), .set_broken_o(set_broken_s), .reg_req_i(req_s), .reg_we_i(1'b0),
    .reg_addr_i(addr_s), .reg_wdata_i(32'h0), .reg_rdata_o(rdata_s), .reg_valid_o(valid_s),
    .irq_o(irq_s), .health_o(health_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that produces the response.
  task automatic acc(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input string tag, input logic [31:0] exp);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; wdata = '0;
    chk({tag, "_vld"}, 32'(valid), 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_health", 32'(health), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_setbrk", 32'(set_broken), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_rdata", rdata, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    acc(0, 3'd0, 0, "rd_status0", 0);
    acc(0, 3'd1, 0, "rd_det0", 0);
    acc(0, 3'd5, 0, "rd_force0", 0);
    cyc(1);
    chk("idle_valid", 32'(valid), 0);
    chk("idle_rdata", rdata, 0);

    // Corrected errors on blocks 0 and 1 for five cycles.
    det = 4'b0011; cor = 4'b0011;
    cyc(5);
    det = '0; cor = '0;
    chk("deg_health", 32'(health), 1);
    acc(0, 3'd1, 0, "det10", 10);
    acc(0, 3'd2, 0, "cor10", 10);
    acc(0, 3'd3, 0, "unc0", 0);
    acc(0, 3'd0, 0, "status_deg", 32'h1);
    acc(1, 3'd6, 32'h1, "wr_irqen", 0);
    cyc(1);
    chk("irq_deg", 32'(irq), 1);
    acc(0, 3'd6, 0, "rd_irqen", 1);

    // One uncorrected error.
    det = 4'b0100; cor = 4'b0000;
    cyc(1);
    det = '0;
    chk("fail_health", 32'(health), 2);
    acc(0, 3'd3, 0, "unc1", 1);
    acc(0, 3'd1, 0, "det11", 11);
    chk("irq_fail_en0", 32'(irq), 0);
    acc(1, 3'd0, 32'h1, "clr1", 0);
    chk("clr1_health", 32'(health), 0);
    acc(0, 3'd1, 0, "det_clr", 0);
    acc(0, 3'd2, 0, "cor_clr", 0);
    acc(0, 3'd3, 0, "unc_clr", 0);
    chk("nom_irq", 32'(irq), 0);

    // Two replicas of block 1 broken.
    is_broken = 12'h018;
    cyc(1);
    chk("brk2_health", 32'(health), 2);
    acc(0, 3'd4, 0, "rd_broken", 32'h18);
    acc(0, 3'd0, 0, "status_fail", 32'h6);
    acc(1, 3'd0, 32'h1, "clr_persist", 0);
    chk("persist_health", 32'(health), 2);
    is_broken = '0;
    acc(1, 3'd0, 32'h1, "clr2", 0);
    chk("clr2_health", 32'(health), 0);

    // Single broken replica only degrades.
    is_broken = 12'h001;
    cyc(1);
    chk("brk1_health", 32'(health), 1);
    cyc(1);
    chk("brk1_irq", 32'(irq), 1);
    acc(1, 3'd0, 32'h1, "clr_brk1", 0);
    chk("clr_brk1_health", 32'(health), 1);
    is_broken = '0;
    acc(1, 3'd0, 32'h1, "clr3", 0);
    chk("clr3_health", 32'(health), 0);

    // Clear in the same cycle as events: events lost.
    det = 4'b0001; cor = 4'b0001;
    acc(1, 3'd0, 32'h1, "clr_ev", 0);
    det = '0; cor = '0;
    acc(0, 3'd1, 0, "det_clr_ev", 0);
    acc(0, 3'd2, 0, "cor_clr_ev", 0);
    chk("clr_ev_health", 32'(health), 0);

    // FORCE register and the unmapped address.
    acc(1, 3'd5, 32'h0000_0924, "wr_force", 0);
    chk("setbrk", 32'(set_broken), 32'h924);
    acc(0, 3'd5, 0, "rd_force", 32'h924);
    acc(1, 3'd7, 32'hffff_ffff, "wr7", 0);
    acc(0, 3'd7, 0, "rd7", 0);

    // Saturation on the narrow-counter instance.
    det_s = 4'b0001; cor_s = 4'b0001;
    cyc(20);
    det_s = '0; cor_s = '0;
    req_s = 1'b1; addr_s = 3'd1;
    cyc(1);
    req_s = 1'b0;
    chk("sat_vld", 32'(valid_s), 1);
    chk("sat_det15", rdata_s, 15);
    req_s = 1'b1; addr_s = 3'd2;
    cyc(1);
    req_s = 1'b0;
    chk("sat_cor15", rdata_s, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
